// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out path.
package vga_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 16;

  // Default 640x480@60 timing, in pixels / lines.
  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [3:0] AMBER_R = 4'hF;
  localparam logic [3:0] AMBER_G = 4'hB;
  localparam logic [3:0] AMBER_B = 4'h0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Colour for one monochrome pixel word: any set bit lights the pixel.
  function automatic rgb444_t pix_to_rgb(input logic [PIX_W-1:0] pix);
    rgb444_t c;
    c = '0;
    if (pix != '0) begin
      c.r = AMBER_R;
      c.g = AMBER_G;
      c.b = AMBER_B;
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, raster counters, visibility and raw (unregistered) syncs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic vis,
  output logic next_vis,
  output logic frame_wrap,
  output logic at_origin,
  output logic hsync_raw,
  output logic vsync_raw
);

  localparam int unsigned HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_VIS + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so the sync end bounds always fit.
  localparam int unsigned HW = $clog2(HT + 1);
  localparam int unsigned VW = $clog2(VT + 1);
  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [VW-1:0] vcnt, vcnt_nxt;
  logic          h_last, v_last;

  assign tick = (div == DW'(CLK_DIV - 1));

  // Divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Next raster position; both counters wrap together at the frame end.
  always_comb begin
    h_last   = (hcnt == HW'(HT - 1));
    v_last   = (vcnt == VW'(VT - 1));
    hcnt_nxt = h_last ? '0 : hcnt + 1'b1;
    vcnt_nxt = vcnt;
    if (h_last) begin
      vcnt_nxt = v_last ? '0 : vcnt + 1'b1;
    end
  end

  // Raster counters advance once per pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
    end
  end

  // Decodes of the current and next position.
  always_comb begin
    vis        = (hcnt < HW'(H_VIS)) && (vcnt < VW'(V_VIS));
    next_vis   = (hcnt_nxt < HW'(H_VIS)) && (vcnt_nxt < VW'(V_VIS));
    frame_wrap = h_last && v_last;
    at_origin  = (hcnt == '0) && (vcnt == '0);
    hsync_raw  = ~SYNC_ACT;
    vsync_raw  = ~SYNC_ACT;
    if ((hcnt >= HW'(H_VIS + H_FP)) && (hcnt < HW'(H_VIS + H_FP + H_SYNC))) begin
      hsync_raw = SYNC_ACT;
    end
    if ((vcnt >= VW'(V_VIS + V_FP)) && (vcnt < VW'(V_VIS + V_FP + V_SYNC))) begin
      vsync_raw = SYNC_ACT;
    end
  end

endmodule

// File: rtl/vga_scan.sv
// VRAM read-side master: raster address generation and registered VGA pin stage.
module vga_scan
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] raddr,
  input  logic [PIX_W-1:0]  rdata,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  // The read data must settle for at least one clock between pixel ticks.
  if (CLK_DIV < 2) begin : g_div_chk
    $error("vga_scan: CLK_DIV must be >= 2");
  end

  logic    tick, vis, next_vis, frame_wrap, at_origin;
  logic    hsync_raw, vsync_raw;
  rgb444_t pix_rgb, rgb_q;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_VIS    (H_VIS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_VIS    (V_VIS),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_ACT (SYNC_ACT)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .vis        (vis),
    .next_vis   (next_vis),
    .frame_wrap (frame_wrap),
    .at_origin  (at_origin),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw)
  );

  // Address tracks the pixel the counters point at: step only when moving onto a
  // visible pixel, so it parks on the last visible address through blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr <= '0;
    end else if (tick) begin
      if (frame_wrap) begin
        raddr <= '0;
      end else if (next_vis) begin
        raddr <= raddr + 1'b1;
      end
    end
  end

  // Colour for the pixel being retired; blanking forces black so stale rdata never shows.
  always_comb begin
    pix_rgb = '0;
    if (vis) begin
      pix_rgb = pix_to_rgb(rdata);
    end
  end

  // Output stage: everything registered on the same tick, one pixel behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q       <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        rgb_q       <= pix_rgb;
        de          <= vis;
        hsync       <= hsync_raw;
        vsync       <= vsync_raw;
        frame_start <= at_origin;
      end
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench: full-size timing for line-level checks, a tiny raster for frame-level checks.
module tb_vga_scan;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default 640x480 instance; VRAM model returns raddr[0] one clock later.
  logic              rst_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [PIX_W-1:0]  rdata_a;
  logic [3:0]        r_a, g_a, b_a;
  logic              hs_a, vs_a, de_a, fs_a;

  vga_scan u_dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .raddr       (raddr_a),
    .rdata       (rdata_a),
    .vga_r       (r_a),
    .vga_g       (g_a),
    .vga_b       (b_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .de          (de_a),
    .frame_start (fs_a)
  );

  always @(posedge clk) rdata_a <= {15'd0, raddr_a[0]};

  // 8x4 visible, 16x8 total, CLK_DIV=3 -> 384 clks per frame; rdata is always all-ones.
  logic              rst_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [PIX_W-1:0]  rdata_b;
  logic [3:0]        r_b, g_b, b_b;
  logic              hs_b, vs_b, de_b, fs_b;

  assign rdata_b = 16'hFFFF;

  vga_scan #(
    .CLK_DIV (3),
    .H_VIS   (8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (3),
    .V_VIS   (4),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .raddr       (raddr_b),
    .rdata       (rdata_b),
    .vga_r       (r_b),
    .vga_g       (g_b),
    .vga_b       (b_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .de          (de_b),
    .frame_start (fs_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int   de_rise, fs_first, fs_cnt, hs_fall1, hs_fall2, vs_fall1;
  int   de_cnt, hs_low, vs_low, leak, fs_t1, fs_t2;
  int   rmax;
  logic prev_de, prev_hs, prev_vs;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_rgb",   {r_a, g_a, b_a}, 12'h000);
    check("a_rst_de",    de_a,    1'b0);
    check("a_rst_hsync", hs_a,    1'b1);
    check("a_rst_vsync", vs_a,    1'b1);
    check("a_rst_raddr", raddr_a, 19'd0);
    check("a_rst_fs",    fs_a,    1'b0);
    check("b_rst_raddr", raddr_b, 19'd0);
    check("b_rst_hsync", hs_b,    1'b1);

    // ---- Two lines of the full-size raster.
    rst_a    = 1'b0;
    de_rise  = -1; fs_first = -1; fs_cnt = 0; hs_fall1 = -1; hs_fall2 = -1;
    de_cnt   = 0;  hs_low   = 0;  leak   = 0;
    prev_de  = 1'b0; prev_hs = 1'b1;
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (de_a && !prev_de && de_rise < 0) de_rise = k;
      if (fs_a) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
      if (!hs_a && prev_hs) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (k <= 3200) begin
        de_cnt += int'(de_a);
        hs_low += int'(!hs_a);
      end
      if (!de_a && ({r_a, g_a, b_a} != 12'h000)) leak++;
      prev_de = de_a;
      prev_hs = hs_a;
      case (k)
        2: begin
          check("a_px0_raddr", raddr_a, 19'd1);
          check("a_px0_rgb",   {r_a, g_a, b_a}, 12'h000);
          check("a_px0_de",    de_a, 1'b1);
        end
        4:    check("a_px1_rgb",   {r_a, g_a, b_a}, 12'hFB0);
        6:    check("a_px2_rgb",   {r_a, g_a, b_a}, 12'h000);
        1278: check("a_px639_raddr", raddr_a, 19'd639);
        1281: begin
          check("a_px639_rgb", {r_a, g_a, b_a}, 12'hFB0);
          check("a_px639_de",  de_a, 1'b1);
        end
        1282: begin
          check("a_blank_de",    de_a, 1'b0);
          check("a_blank_raddr", raddr_a, 19'd639);
        end
        1599: check("a_hold_raddr",  raddr_a, 19'd639);
        1601: check("a_line1_raddr", raddr_a, 19'd640);
        default: ;
      endcase
    end
    check("a_de_rise_clk",  de_rise,  2);
    check("a_fs_first_clk", fs_first, 2);
    check("a_fs_count",     fs_cnt,   1);
    check("a_hs_fall_clk",  hs_fall1, 1314);
    check("a_line_period",  hs_fall2 - hs_fall1, 1600);
    check("a_de_clks",      de_cnt,   2560);
    check("a_hs_low_clks",  hs_low,   384);
    check("a_blank_leak",   leak,     0);

    // ---- Mid-line reset (line 2, visible): next clock shows reset values.
    rst_a = 1'b1;
    @(negedge clk);
    check("a_mid_rgb",   {r_a, g_a, b_a}, 12'h000);
    check("a_mid_de",    de_a,    1'b0);
    check("a_mid_hsync", hs_a,    1'b1);
    check("a_mid_vsync", vs_a,    1'b1);
    check("a_mid_raddr", raddr_a, 19'd0);
    check("a_mid_fs",    fs_a,    1'b0);
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) check("a_rel_fs_early", fs_a, 1'b0);
      if (k == 2) begin
        check("a_rel_fs",    fs_a,    1'b1);
        check("a_rel_raddr", raddr_a, 19'd1);
      end
      if (k == 3) check("a_rel_fs_pulse", fs_a, 1'b0);
    end

    // ---- Small raster: frame wrap, vsync, frame_start period, masking.
    rst_b   = 1'b0;
    fs_cnt  = 0; fs_t1 = -1; fs_t2 = -1; vs_fall1 = -1;
    de_cnt  = 0; vs_low = 0; leak = 0; rmax = 0;
    prev_vs = 1'b1;
    for (int k = 1; k <= 870; k++) begin
      @(negedge clk);
      if (fs_b) begin
        fs_cnt++;
        if (fs_t1 < 0) fs_t1 = k;
        else if (fs_t2 < 0) fs_t2 = k;
      end
      if (!vs_b && prev_vs && vs_fall1 < 0) vs_fall1 = k;
      prev_vs = vs_b;
      if (k <= 384) begin
        de_cnt += int'(de_b);
        vs_low += int'(!vs_b);
      end
      if (int'(raddr_b) > rmax) rmax = int'(raddr_b);
      if ({r_b, g_b, b_b} != (de_b ? 12'hFB0 : 12'h000)) leak++;
      case (k)
        3:   check("b_px0_raddr",   raddr_b, 19'd1);
        24:  check("b_hold_raddr",  raddr_b, 19'd7);
        48:  check("b_line1_raddr", raddr_b, 19'd8);
        383: check("b_prewrap_raddr", raddr_b, 19'd31);
        384: check("b_wrap_raddr",  raddr_b, 19'd0);
        default: ;
      endcase
    end
    check("b_raddr_max",   rmax,        31);
    check("b_fs_count",    fs_cnt,      3);
    check("b_fs_first",    fs_t1,       3);
    check("b_fs_period",   fs_t2 - fs_t1, 384);
    check("b_vs_fall_clk", vs_fall1,    243);
    check("b_vs_low_clks", vs_low,      96);
    check("b_de_clks",     de_cnt,      96);
    check("b_rgb_mask",    leak,        0);
    check("b_pre_rst_de",  de_b,        1'b1);

    // ---- Mid-frame reset on the small raster (line 2, pixel 2).
    rst_b = 1'b1;
    @(negedge clk);
    check("b_mid_raddr", raddr_b, 19'd0);
    check("b_mid_de",    de_b,    1'b0);
    check("b_mid_rgb",   {r_b, g_b, b_b}, 12'h000);
    check("b_mid_sync",  {hs_b, vs_b}, 2'b11);
    rst_b = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) check("b_rel_fs_early", fs_b, 1'b0);
      if (k == 3) begin
        check("b_rel_fs",    fs_b,    1'b1);
        check("b_rel_raddr", raddr_b, 19'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
